step_sequencer: RTL and testbench

//  Per-axis step/dir generator between the CPU register bank and one motor driver (gp step/dir pins).
//  The CPU pushes 32-bit move commands into a small FIFO. The block plays each command out as

---
 rtl/step_sequencer.sv | 170 +++++++++++++++++
 tb/tb_step_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Step/dir generator: a command FIFO feeding a SETUP/HIGH/LOW pulse engine for one motor driver.
// Define STEP_SEQ_POSITION_EN to add the signed position_out step counter.
module step_sequencer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int PULSE_WIDTH = 12,
   parameter int DIR_SETUP   = 6
) (
   input  logic                        clk_in,
   input  logic                        reset_n_in,
   input  logic [31:0]                 cmd_data_in,
   input  logic                        cmd_valid_in,
   output logic                        cmd_ready_out,
   input  logic                        abort_in,
   output logic                        step_out,
   output logic                        dir_out,
   output logic                        busy_out,
   output logic                        done_out,
   output logic [$clog2(FIFO_DEPTH):0] level_out
`ifdef STEP_SEQ_POSITION_EN
   ,
   output logic [31:0]                 position_out
`endif
);

   localparam int          AW         = $clog2(FIFO_DEPTH);
   localparam logic [16:0] MIN_PERIOD = 17'(2 * PULSE_WIDTH);
   localparam logic [16:0] HIGH_LOAD  = 17'(PULSE_WIDTH - 1);
   localparam logic [16:0] SETUP_LOAD = 17'(DIR_SETUP - 1);
   localparam logic [16:0] LOW_OFFS   = 17'(PULSE_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   logic          push;
   logic          pop;
   logic [31:0]   head;
   logic [16:0]   head_period;

   state_t        state;
   logic [16:0]   cnt;
   logic [16:0]   period_eff;
   logic [14:0]   steps;
   logic          dir_q;
   logic          abort_pending;

   // abort_in wins over both the CPU push and the engine pop
   assign cmd_ready_out = (level != (AW + 1)'(FIFO_DEPTH));
   assign push          = cmd_valid_in && cmd_ready_out && !abort_in;
   assign pop           = (state == IDLE) && (level != '0) && !abort_in;
   assign head          = mem[rd_ptr];
   assign head_period   = {1'b0, head[15:0]};
   assign level_out     = level;
   assign busy_out      = (state != IDLE) || (level != '0) || step_out;

   // NOTE: command storage is not reset; pointers and level alone define which entries are valid.
   always_ff @(posedge clk_in) begin
      if (push) mem[wr_ptr] <= cmd_data_in;
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (abort_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   // NOTE: step_out/dir_out are registered copies of the engine state, so both pins lag it by one
   // cycle; the lag is uniform, which keeps pulse width, period and dir setup exact at the pins.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state         <= IDLE;
         cnt           <= '0;
         period_eff    <= '0;
         steps         <= '0;
         dir_q         <= 1'b0;
         abort_pending <= 1'b0;
         step_out      <= 1'b0;
         dir_out       <= 1'b0;
         done_out      <= 1'b0;
      end else begin
         done_out <= 1'b0;
         step_out <= (state == HIGH);
         dir_out  <= dir_q;
         case (state)
            IDLE: begin
               if (pop) begin
                  period_eff    <= (head_period < MIN_PERIOD) ? MIN_PERIOD : head_period;
                  steps         <= head[30:16];
                  abort_pending <= 1'b0;
                  if (head[30:16] == '0) begin
                     done_out <= 1'b1;
                  end else if (head[31] != dir_q) begin
                     dir_q <= head[31];
                     cnt   <= SETUP_LOAD;
                     state <= SETUP;
                  end else begin
                     cnt   <= HIGH_LOAD;
                     state <= HIGH;
                  end
               end
            end
            SETUP: begin
               if (abort_in) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  cnt   <= HIGH_LOAD;
                  state <= HIGH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HIGH: begin
               // an abort here only takes effect once the pulse has its full width
               if (cnt == '0) begin
                  if (abort_in || abort_pending) begin
                     state <= IDLE;
                  end else begin
                     steps <= steps - 1'b1;
                     cnt   <= period_eff - LOW_OFFS;
                     state <= LOW;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
                  if (abort_in) abort_pending <= 1'b1;
               end
            end
            LOW: begin
               if (abort_in) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  if (steps != '0) begin
                     cnt   <= HIGH_LOAD;
                     state <= HIGH;
                  end else begin
                     done_out <= 1'b1;
                     state    <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef STEP_SEQ_POSITION_EN
   // the first HIGH cycle is the one where step_out is about to rise
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         position_out <= '0;
      end else if ((state == HIGH) && !step_out) begin
         position_out <= dir_out ? position_out + 32'd1 : position_out - 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed and random command streams checked against a timeline model.
// Define STEP_SEQ_POSITION_EN to also check position_out.
module tb_step_sequencer;

   localparam int PW    = 12;
   localparam int DS    = 6;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] cmd_data;
   logic        cmd_valid;
   logic        ready;
   logic        abort;
   logic        step;
   logic        dir;
   logic        busy;
   logic        done;
   logic [2:0]  level;
`ifdef STEP_SEQ_POSITION_EN
   logic [31:0] position;
`endif

   step_sequencer #(.FIFO_DEPTH(DEPTH), .PULSE_WIDTH(PW), .DIR_SETUP(DS)) dut (
      .clk_in(clk), .reset_n_in(reset_n), .cmd_data_in(cmd_data), .cmd_valid_in(cmd_valid),
      .cmd_ready_out(ready), .abort_in(abort), .step_out(step), .dir_out(dir),
      .busy_out(busy), .done_out(done), .level_out(level)
`ifdef STEP_SEQ_POSITION_EN
      , .position_out(position)
`endif
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad   = 0;
   longint cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // observed pin activity, stamped with the number of the edge that produced it
   longint obs_rise[$];
   logic   obs_rdir[$];
   longint obs_width[$];
   longint obs_done[$];
   longint last_rise = 0;
   longint dir_chg   = 0;
   logic   prev_step = 1'b0;
   logic   prev_dir  = 1'b0;

   always @(negedge clk) begin
      if (step && !prev_step) begin
         obs_rise.push_back(cyc);
         obs_rdir.push_back(dir);
         last_rise <= cyc;
      end
      if (!step && prev_step) obs_width.push_back(cyc - last_rise);
      if (done) obs_done.push_back(cyc);
      if (dir != prev_dir) dir_chg <= cyc;
      prev_step <= step;
      prev_dir  <= dir;
   end

   // reference model: commands played strictly in order on an absolute edge timeline
   logic [31:0] cmds[$];
   longint      exp_rise[$];
   logic        exp_rdir[$];
   longint      exp_done[$];
   longint      exp_end;
   logic        model_dir = 1'b0;
   int          exp_pos   = 0;

   task automatic build_model(input longint first_pop);
      longint p = first_pop;
      exp_rise.delete();
      exp_rdir.delete();
      exp_done.delete();
      foreach (cmds[i]) begin
         logic [31:0] c = cmds[i];
         int     n_steps = int'(c[30:16]);
         int     pe = (int'(c[15:0]) < 2 * PW) ? 2 * PW : int'(c[15:0]);
         longint h;
         if (n_steps == 0) begin
            exp_done.push_back(p);
            p = p + 1;
         end else begin
            h = p + ((c[31] != model_dir) ? DS : 0);
            model_dir = c[31];
            for (int s = 0; s < n_steps; s++) begin
               exp_rise.push_back(h + 1 + longint'(s) * pe);
               exp_rdir.push_back(c[31]);
               exp_pos = exp_pos + (c[31] ? 1 : -1);
            end
            exp_done.push_back(h + longint'(n_steps) * pe);
            p = h + longint'(n_steps) * pe + 1;
         end
      end
      exp_end = p;
   endtask

   task automatic clear_obs;
      obs_rise.delete();
      obs_rdir.delete();
      obs_width.delete();
      obs_done.delete();
   endtask

   task automatic push_cmds(output longint first_edge);
      first_edge = 0;
      foreach (cmds[i]) begin
         @(negedge clk);
         if (i == 0) first_edge = cyc + 1;
         cmd_data  = cmds[i];
         cmd_valid = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic play;
      longint k;
      push_cmds(k);
      build_model(k + 1);
      while (cyc < exp_end + 3) @(negedge clk);
   endtask

   task automatic test_reset(input string tag);
      total++; if (step !== 1'b0)  begin bad++; $display("FAIL %s_step: got %b want 0", tag, step); end
      total++; if (dir !== 1'b0)   begin bad++; $display("FAIL %s_dir: got %b want 0", tag, dir); end
      total++; if (done !== 1'b0)  begin bad++; $display("FAIL %s_done: got %b want 0", tag, done); end
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL %s_ready: got %b want 1", tag, ready); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL %s_level: got %0d want 0", tag, level); end
`ifdef STEP_SEQ_POSITION_EN
      total++; if (position !== 32'd0) begin bad++; $display("FAIL %s_pos: got %0d want 0", tag, position); end
`endif
   endtask

   task automatic test_basic;
      clear_obs();
      cmds = {32'h8003_0020};
      play();
      total++;
      if (obs_rise.size() != 3) begin
         bad++; $display("FAIL basic_count: got %0d pulses want 3", obs_rise.size());
      end else begin
         foreach (exp_rise[i]) begin
            total++;
            if (obs_rise[i] !== exp_rise[i] || obs_rdir[i] !== 1'b1) begin
               bad++; $display("FAIL basic_rise%0d: got t=%0d dir=%b want t=%0d dir=1", i, obs_rise[i], obs_rdir[i], exp_rise[i]);
            end
         end
         total++;
         if (obs_rise[0] - dir_chg !== longint'(DS)) begin
            bad++; $display("FAIL basic_dir_setup: got %0d want %0d", obs_rise[0] - dir_chg, DS);
         end
      end
      foreach (obs_width[i]) begin
         total++; if (obs_width[i] !== longint'(PW)) begin bad++; $display("FAIL basic_width: got %0d want %0d", obs_width[i], PW); end
      end
      total++;
      if (obs_done.size() != 1 || obs_done[0] !== exp_done[0]) begin
         bad++; $display("FAIL basic_done: got %0d pulses want 1 at t=%0d", obs_done.size(), exp_done[0]);
      end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy: got %b want 0", busy); end
   endtask

   task automatic test_clamp;
      clear_obs();
      cmds = {32'h0002_0005};
      play();
      total++;
      if (obs_rise.size() != 2) begin
         bad++; $display("FAIL clamp_count: got %0d pulses want 2", obs_rise.size());
      end else begin
         total++;
         if (obs_rise[1] - obs_rise[0] !== longint'(2 * PW)) begin
            bad++; $display("FAIL clamp_spacing: got %0d want %0d", obs_rise[1] - obs_rise[0], 2 * PW);
         end
         total++;
         if (obs_rise[0] !== exp_rise[0]) begin
            bad++; $display("FAIL clamp_first: got t=%0d want t=%0d", obs_rise[0], exp_rise[0]);
         end
      end
      total++; if (obs_done.size() != 1) begin bad++; $display("FAIL clamp_done: got %0d want 1", obs_done.size()); end
   endtask

   task automatic test_fifo_full;
      longint k;
      clear_obs();
      @(negedge clk);
      k = cyc + 1;
      cmd_data  = 32'h0001_0040;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 4) begin
            total++; if (ready !== 1'b0) begin bad++; $display("FAIL fifo_ready: got %b want 0", ready); end
            total++; if (level !== 3'd4) begin bad++; $display("FAIL fifo_level: got %0d want 4", level); end
         end
         cmd_data  = (i == 4) ? 32'h8007_0040 : 32'h0001_0040;
         cmd_valid = 1'b1;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      total++; if (level !== 3'd4) begin bad++; $display("FAIL fifo_drop_level: got %0d want 4", level); end
      cmds = {32'h0001_0040, 32'h0001_0040, 32'h0001_0040, 32'h0001_0040, 32'h0001_0040};
      build_model(k + 1);
      while (cyc < exp_end + 3) @(negedge clk);
      total++;
      if (obs_rise.size() != 5) begin
         bad++; $display("FAIL fifo_count: got %0d pulses want 5", obs_rise.size());
      end else begin
         total++;
         if (obs_rise[0] !== k + 2) begin bad++; $display("FAIL fifo_latency: got t=%0d want t=%0d", obs_rise[0], k + 2); end
         foreach (exp_rise[i]) begin
            total++;
            if (obs_rise[i] !== exp_rise[i] || obs_rdir[i] !== 1'b0) begin
               bad++; $display("FAIL fifo_rise%0d: got t=%0d dir=%b want t=%0d dir=0", i, obs_rise[i], obs_rdir[i], exp_rise[i]);
            end
         end
      end
      total++; if (obs_done.size() != 5) begin bad++; $display("FAIL fifo_done: got %0d want 5", obs_done.size()); end
   endtask

   task automatic test_zero_steps;
      logic d0;
      clear_obs();
      d0 = model_dir;
      cmds = {{~d0, 31'h0000_0040}};
      play();
      total++; if (obs_rise.size() != 0) begin bad++; $display("FAIL zero_pulses: got %0d want 0", obs_rise.size()); end
      total++; if (dir !== d0) begin bad++; $display("FAIL zero_dir: got %b want %b", dir, d0); end
      total++;
      if (obs_done.size() != 1 || obs_done[0] !== exp_done[0]) begin
         bad++; $display("FAIL zero_done: got %0d pulses want 1 at t=%0d", obs_done.size(), exp_done[0]);
      end
   endtask

   task automatic test_abort;
      longint k;
      longint r;
      int     n = 0;
      clear_obs();
      cmds = {32'h0064_0100, 32'h0001_0040, 32'h0001_0040};
      push_cmds(k);
      while (obs_rise.size() == 0 && n < 100) begin @(negedge clk); n++; end
      total++;
      if (obs_rise.size() == 0) begin
         bad++; $display("FAIL abort_start: no step pulse within %0d cycles", n);
      end else begin
         r = obs_rise[0];
         while (cyc < r + 2) @(negedge clk);
         abort     = 1'b1;
         cmd_data  = 32'h0001_0040;
         cmd_valid = 1'b1;
         @(negedge clk);
         abort     = 1'b0;
         cmd_valid = 1'b0;
         total++; if (level !== 3'd0) begin bad++; $display("FAIL abort_flush: got level %0d want 0", level); end
         while (cyc < r + 300) @(negedge clk);
         total++; if (obs_rise.size() != 1) begin bad++; $display("FAIL abort_pulses: got %0d want 1", obs_rise.size()); end
         total++;
         if (obs_width.size() != 1 || obs_width[0] !== longint'(PW)) begin
            bad++; $display("FAIL abort_width: got %0d falls, first width %0d, want 1 of %0d", obs_width.size(),
                            (obs_width.size() > 0) ? obs_width[0] : -1, PW);
         end
         total++; if (obs_done.size() != 0) begin bad++; $display("FAIL abort_done: got %0d want 0", obs_done.size()); end
         total++; if (busy !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL abort_idle: got busy=%b level=%0d want 0/0", busy, level); end
         model_dir = 1'b0;
         exp_pos   = exp_pos - 1;
      end
   endtask

   task automatic test_random;
      for (int it = 0; it < 6; it++) begin
         clear_obs();
         cmds.delete();
         for (int j = 0; j < int'($urandom_range(1, DEPTH)); j++) begin
            cmds.push_back({1'($urandom_range(0, 1)), 15'($urandom_range(0, 4)), 16'($urandom_range(0, 80))});
         end
         play();
         total++;
         if (obs_rise.size() != exp_rise.size()) begin
            bad++; $display("FAIL rand%0d_count: got %0d pulses want %0d", it, obs_rise.size(), exp_rise.size());
         end else begin
            foreach (exp_rise[i]) begin
               total++;
               if (obs_rise[i] !== exp_rise[i] || obs_rdir[i] !== exp_rdir[i]) begin
                  bad++; $display("FAIL rand%0d_rise%0d: got t=%0d dir=%b want t=%0d dir=%b", it, i,
                                  obs_rise[i], obs_rdir[i], exp_rise[i], exp_rdir[i]);
               end
            end
         end
         foreach (obs_width[i]) begin
            total++; if (obs_width[i] !== longint'(PW)) begin bad++; $display("FAIL rand%0d_width: got %0d want %0d", it, obs_width[i], PW); end
         end
         total++;
         if (obs_done.size() != exp_done.size()) begin
            bad++; $display("FAIL rand%0d_done: got %0d want %0d", it, obs_done.size(), exp_done.size());
         end else begin
            foreach (exp_done[i]) begin
               total++;
               if (obs_done[i] !== exp_done[i]) begin
                  bad++; $display("FAIL rand%0d_done%0d: got t=%0d want t=%0d", it, i, obs_done[i], exp_done[i]);
               end
            end
         end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand%0d_busy: got %b want 0", it, busy); end
      end
   endtask

`ifdef STEP_SEQ_POSITION_EN
   task automatic test_position;
      clear_obs();
      cmds = {32'h800A_001E, 32'h0004_0000};
      play();
      total++;
      if (position !== 32'(exp_pos)) begin
         bad++; $display("FAIL position: got %0d want %0d", $signed(position), exp_pos);
      end
   endtask
`endif

   task automatic test_async_reset;
      longint k;
      int     n = 0;
      clear_obs();
      cmds = {32'h8005_0040};
      push_cmds(k);
      while (obs_rise.size() == 0 && n < 100) begin @(negedge clk); n++; end
      total++;
      if (obs_rise.size() == 0) begin
         bad++; $display("FAIL areset_start: no step pulse within %0d cycles", n);
      end else begin
         @(negedge clk);
         #2 reset_n = 1'b0;
         #1 test_reset("areset");
      end
      reset_n = 1'b0;
      @(negedge clk);
      reset_n   = 1'b1;
      model_dir = 1'b0;
      exp_pos   = 0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish within 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      cmd_data  = '0;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      repeat (3) @(negedge clk);
      test_reset("in_reset");
      reset_n = 1'b1;
      @(negedge clk);
      test_reset("after_reset");
      test_basic();
      test_clamp();
      test_fifo_full();
      test_zero_steps();
      test_abort();
      test_random();
`ifdef STEP_SEQ_POSITION_EN
      test_position();
`endif
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
